// File: rtl/loader_pkg.sv
// Shared state encoding and error codes for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    FINISH
  } loader_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_BAD_COUNT = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/word_assembler.sv
// Shifts accepted bytes (MSB first) into an instruction word and pulses wordValid
// for one cycle after the final byte of each word has been accepted.
module word_assembler #(
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic                         clear_i,
  input  logic                         accept_i,
  input  logic [7:0]                   byte_i,
  output logic                         lastByte_o,
  output logic                         wordValid_o,
  output logic [INSTRUCTION_WIDTH-1:0] word_o
);
  import loader_pkg::*;

  localparam int BYTES = INSTRUCTION_WIDTH / 8;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [INSTRUCTION_WIDTH-1:0] wordQ, wordD;
  logic [CW-1:0]                countQ, countD;
  logic                         validQ, validD;

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      wordQ  <= '0;
      countQ <= '0;
      validQ <= 1'b0;
    end else begin
      wordQ  <= wordD;
      countQ <= countD;
      validQ <= validD;
    end
  end

  always_comb begin
    wordD  = wordQ;
    countD = countQ;
    validD = 1'b0;
    if (clear_i) begin
      countD = '0;
    end else if (accept_i) begin
      wordD = (wordQ << 8) | INSTRUCTION_WIDTH'(byte_i);
      if (countQ == LAST) begin
        countD = '0;
        validD = 1'b1;
      end else begin
        countD = countQ + CW'(1);
      end
    end
  end

  assign lastByte_o  = (countQ == LAST);
  assign wordValid_o = validQ;
  assign word_o      = wordQ;

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream (sync, word count, data, XOR check) and writes the
// assembled instruction words to memory from address 0, holding the CPU meanwhile.
module program_loader
  import loader_pkg::*;
#(
  parameter int         INSTRUCTION_WIDTH = 32,
  parameter int         PC_WIDTH          = 8,
  parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES    = 1000
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic [7:0]                   byteData,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         writeEnable,
  output logic [PC_WIDTH-1:0]          writeAddress,
  output logic [INSTRUCTION_WIDTH-1:0] writeData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic [1:0]                   errorCode
);

  localparam int WC        = PC_WIDTH + 1;
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MAX_WORDS = 2 ** PC_WIDTH;

  loader_state_e       stateQ, stateD;
  logic                byteReadyQ, byteReadyD;
  logic                cpuHoldQ, cpuHoldD;
  logic                loadDoneQ, loadDoneD;
  logic [1:0]          errorQ, errorD;
  logic [7:0]          checksumQ, checksumD;
  logic [PC_WIDTH-1:0] addrQ, addrD;
  logic [WC-1:0]       wordCountQ, wordCountD;
  logic [WC-1:0]       nWordsQ, nWordsD;
  logic [TW-1:0]       timeoutQ, timeoutD;

  logic accept, asmAccept, asmClear, asmLast;

  assign accept = byteValid && byteReadyQ;

  word_assembler #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)
  ) u_word_assembler (
    .clock      (clock),
    .isResetN   (isResetN),
    .clear_i    (asmClear),
    .accept_i   (asmAccept),
    .byte_i     (byteData),
    .lastByte_o (asmLast),
    .wordValid_o(writeEnable),
    .word_o     (writeData)
  );

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      stateQ     <= IDLE;
      byteReadyQ <= 1'b0;
      cpuHoldQ   <= 1'b0;
      loadDoneQ  <= 1'b0;
      errorQ     <= ERR_NONE;
      checksumQ  <= '0;
      addrQ      <= '0;
      wordCountQ <= '0;
      nWordsQ    <= '0;
      timeoutQ   <= '0;
    end else begin
      stateQ     <= stateD;
      byteReadyQ <= byteReadyD;
      cpuHoldQ   <= cpuHoldD;
      loadDoneQ  <= loadDoneD;
      errorQ     <= errorD;
      checksumQ  <= checksumD;
      addrQ      <= addrD;
      wordCountQ <= wordCountD;
      nWordsQ    <= nWordsD;
      timeoutQ   <= timeoutD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    cpuHoldD   = cpuHoldQ;
    loadDoneD  = 1'b0;
    errorD     = errorQ;
    checksumD  = checksumQ;
    addrD      = writeEnable ? addrQ + PC_WIDTH'(1) : addrQ;
    wordCountD = wordCountQ;
    nWordsD    = nWordsQ;
    timeoutD   = timeoutQ;
    asmAccept  = 1'b0;
    asmClear   = 1'b0;

    case (stateQ)
      IDLE: begin
        if (accept && byteData == SYNC_BYTE) begin
          stateD     = COUNT;
          cpuHoldD   = 1'b1;
          errorD     = ERR_NONE;
          checksumD  = '0;
          addrD      = '0;
          wordCountD = '0;
          nWordsD    = '0;
          asmClear   = 1'b1;
        end
      end
      COUNT: begin
        if (accept) begin
          if (byteData == 8'd0 || int'(byteData) > MAX_WORDS) begin
            stateD = FINISH;
            errorD = ERR_BAD_COUNT;
          end else begin
            stateD    = DATA;
            nWordsD   = WC'(byteData);
            checksumD = byteData;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asmAccept = 1'b1;
          checksumD = checksumQ ^ byteData;
          if (asmLast) begin
            wordCountD = wordCountQ + WC'(1);
            // Leave DATA as the last byte lands so the check byte can follow immediately.
            if (wordCountQ + WC'(1) == nWordsQ) stateD = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          stateD = FINISH;
          if (byteData == checksumQ) begin
            loadDoneD = 1'b1;
            cpuHoldD  = 1'b0;
          end else begin
            errorD = ERR_CHECKSUM;
          end
        end
      end
      FINISH: stateD = IDLE;
      default: stateD = IDLE;
    endcase

    if (stateQ == COUNT || stateQ == DATA || stateQ == CHECK) begin
      if (accept) begin
        timeoutD = '0;
      end else if (timeoutQ == TW'(TIMEOUT_CYCLES - 1)) begin
        stateD   = FINISH;
        errorD   = ERR_TIMEOUT;
        timeoutD = '0;
      end else begin
        timeoutD = timeoutQ + TW'(1);
      end
    end else begin
      timeoutD = '0;
    end
  end

  assign byteReadyD   = (stateD != FINISH);
  assign byteReady    = byteReadyQ;
  assign writeAddress = addrQ;
  assign cpuHold      = cpuHoldQ;
  assign loadDone     = loadDoneQ;
  assign errorCode    = errorQ;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are built from a word list, expected
// memory writes are queued as bytes are issued and a monitor checks each strobe.
module tb_program_loader;

  localparam int         TIMEOUT = 1000;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic        clock = 1'b0;
  logic        isResetN = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        writeEnable;
  logic [7:0]  writeAddress;
  logic [31:0] writeData;
  logic        cpuHold;
  logic        loadDone;
  logic [1:0]  errorCode;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  wr_t         monEntry;
  int          writeCycles[$];
  logic [31:0] frameWords[$];
  int          cycleCount = 0;
  int          loadDoneCount = 0;
  int          assertCount = 0;
  int          failCount = 0;

  program_loader #(
    .INSTRUCTION_WIDTH(32),
    .PC_WIDTH         (8),
    .SYNC_BYTE        (SYNC),
    .TIMEOUT_CYCLES   (TIMEOUT)
  ) dut (
    .clock       (clock),
    .isResetN    (isResetN),
    .byteData    (byteData),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .writeEnable (writeEnable),
    .writeAddress(writeAddress),
    .writeData   (writeData),
    .cpuHold     (cpuHold),
    .loadDone    (loadDone),
    .errorCode   (errorCode)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clock) begin
    if (isResetN && writeEnable) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected write", 64'(writeAddress), 64'hFFFF);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("write address", 64'(writeAddress), 64'(monEntry.addr));
        checkOutput("write data", 64'(writeData), 64'(monEntry.data));
      end
      writeCycles.push_back(cycleCount);
    end
    if (isResetN && loadDone) loadDoneCount++;
  end

  task automatic idleBus();
    @(negedge clock);
    byteValid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int gap;
    int tries;
    gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
    repeat (gap) begin
      @(negedge clock);
      byteValid = 1'b0;
    end
    @(negedge clock);
    byteData  = b;
    byteValid = 1'b1;
    tries = 0;
    while (!byteReady && tries < 20) begin
      @(negedge clock);
      tries++;
    end
    if (!byteReady) checkOutput("byteReady wait", 64'(byteReady), 64'h1);
    @(posedge clock);
  endtask

  // Sends one frame built from frameWords and checks the loader's end state.
  task automatic applyStimulus(input int nWords, input int gapMax, input bit forceCheck,
                               input logic [7:0] checkValue, input string tag);
    logic [7:0] sum;
    logic [7:0] chk;
    logic [7:0] bt;
    logic [1:0] expErr;
    int         doneBefore;
    wr_t        e;
    doneBefore = loadDoneCount;
    writeCycles.delete();
    sendByte(SYNC, gapMax);
    sum = 8'(nWords);
    sendByte(8'(nWords), gapMax);
    if (nWords == 0) begin
      expErr = 2'd1;
    end else begin
      for (int w = 0; w < nWords; w++) begin
        for (int b = 3; b >= 0; b--) begin
          bt = frameWords[w][8*b +: 8];
          sum ^= bt;
          if (b == 0) begin
            e.addr = 8'(w);
            e.data = frameWords[w];
            expQ.push_back(e);
          end
          sendByte(bt, gapMax);
        end
      end
      chk = forceCheck ? checkValue : sum;
      sendByte(chk, gapMax);
      expErr = (chk == sum) ? 2'd0 : 2'd2;
    end
    idleBus();
    repeat (4) @(negedge clock);
    checkOutput({tag, " errorCode"}, 64'(errorCode), 64'(expErr));
    checkOutput({tag, " cpuHold"}, 64'(cpuHold), (expErr == 2'd0) ? 64'h0 : 64'h1);
    checkOutput({tag, " loadDone pulses"}, 64'(loadDoneCount - doneBefore), (expErr == 2'd0) ? 64'h1 : 64'h0);
    checkOutput({tag, " pending writes"}, 64'(expQ.size()), 64'h0);
    checkOutput({tag, " byteReady idle"}, 64'(byteReady), 64'h1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] gb;
    int         n;
    bit         corrupt;
    int         waited;

    #12;
    checkOutput("reset byteReady", 64'(byteReady), 64'h0);
    checkOutput("reset writeEnable", 64'(writeEnable), 64'h0);
    checkOutput("reset writeAddress", 64'(writeAddress), 64'h0);
    checkOutput("reset writeData", 64'(writeData), 64'h0);
    checkOutput("reset cpuHold", 64'(cpuHold), 64'h0);
    checkOutput("reset loadDone", 64'(loadDone), 64'h0);
    checkOutput("reset errorCode", 64'(errorCode), 64'h0);
    @(negedge clock);
    isResetN = 1'b1;
    repeat (2) @(negedge clock);

    frameWords.delete();
    frameWords.push_back(32'h12345678);
    applyStimulus(1, 0, 1'b1, 8'h09, "one word");

    frameWords.delete();
    frameWords.push_back(32'hDEADBEEF);
    frameWords.push_back(32'h0BADF00D);
    frameWords.push_back(32'hA5A5A5A5);
    applyStimulus(3, 0, 1'b0, 8'h00, "back-to-back");
    if (writeCycles.size() == 3) begin
      checkOutput("b2b spacing 0-1", 64'(writeCycles[1] - writeCycles[0]), 64'd4);
      checkOutput("b2b spacing 1-2", 64'(writeCycles[2] - writeCycles[1]), 64'd4);
    end else begin
      checkOutput("b2b write count", 64'(writeCycles.size()), 64'd3);
    end

    frameWords.delete();
    frameWords.push_back(32'h12345678);
    applyStimulus(1, 0, 1'b1, 8'h00, "bad check");

    frameWords.delete();
    applyStimulus(0, 0, 1'b0, 8'h00, "count zero");
    frameWords.push_back(32'hCAFE0001);
    frameWords.push_back(32'h00000000);
    applyStimulus(2, 1, 1'b0, 8'h00, "after count zero");

    sendByte(SYNC, 0);
    sendByte(8'h02, 0);
    idleBus();
    repeat (990) @(negedge clock);
    checkOutput("timeout not early", 64'(errorCode), 64'h0);
    waited = 0;
    while (errorCode != 2'd3 && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("timeout errorCode", 64'(errorCode), 64'h3);
    checkOutput("timeout cpuHold", 64'(cpuHold), 64'h1);
    repeat (2) @(negedge clock);
    checkOutput("timeout back to idle", 64'(byteReady), 64'h1);

    sendByte(8'h00, 0);
    sendByte(8'hFF, 0);
    frameWords.delete();
    frameWords.push_back(32'h89ABCDEF);
    applyStimulus(1, 0, 1'b0, 8'h00, "garbage first");

    begin
      wr_t e;
      sendByte(SYNC, 0);
      sendByte(8'h02, 0);
      sendByte(8'h11, 0);
      sendByte(8'h22, 0);
      sendByte(8'h33, 0);
      e.addr = 8'h00;
      e.data = 32'h11223344;
      expQ.push_back(e);
      sendByte(8'h44, 0);
      sendByte(8'h55, 0);
      sendByte(8'h66, 0);
      #2;
      isResetN  = 1'b0;
      byteValid = 1'b0;
      #1;
      checkOutput("midreset byteReady", 64'(byteReady), 64'h0);
      checkOutput("midreset writeEnable", 64'(writeEnable), 64'h0);
      checkOutput("midreset writeAddress", 64'(writeAddress), 64'h0);
      checkOutput("midreset writeData", 64'(writeData), 64'h0);
      checkOutput("midreset cpuHold", 64'(cpuHold), 64'h0);
      checkOutput("midreset errorCode", 64'(errorCode), 64'h0);
      checkOutput("midreset pending writes", 64'(expQ.size()), 64'h0);
      @(negedge clock);
      isResetN = 1'b1;
      repeat (2) @(negedge clock);
    end

    for (int f = 0; f < 15; f++) begin
      repeat ($urandom_range(2, 0)) begin
        do gb = 8'($urandom); while (gb == SYNC);
        sendByte(gb, 1);
      end
      n = int'($urandom_range(6, 1));
      frameWords.delete();
      for (int w = 0; w < n; w++) frameWords.push_back($urandom);
      corrupt = ($urandom_range(3, 0) == 0);
      if (corrupt) begin
        logic [7:0] good;
        good = 8'(n);
        for (int w = 0; w < n; w++)
          good ^= frameWords[w][31:24] ^ frameWords[w][23:16] ^ frameWords[w][15:8] ^ frameWords[w][7:0];
        applyStimulus(n, 2, 1'b1, good ^ 8'($urandom_range(255, 1)), "random bad");
      end else begin
        applyStimulus(n, 2, 1'b0, 8'h00, "random");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the CPU instruction memory: receives a framed byte stream, assembles INSTRUCTION_WIDTH-bit words and writes them to consecutive memory addresses starting at 0.
- Holds the CPU in reset while a program is loading.
- Sits between a byte source (UART receiver or bench) and the memory write port; cpuHold is ORed into the CPU's isReset.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width; must be a multiple of 8
PC_WIDTH, 8, memory address width
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000, maximum idle cycles between bytes inside a frame

Ports:
clock  input  1  system clock, rising edge
isResetN  input  1  asynchronous, active-low reset
byteData  input  8  incoming byte
byteValid  input  1  byteData is valid
byteReady  output  1  loader can accept a byte
writeEnable  output  1  memory write strobe, one cycle per word
writeAddress  output  PC_WIDTH  word address
writeData  output  INSTRUCTION_WIDTH  word to write
cpuHold  output  1  keep CPU in reset
loadDone  output  1  one-cycle pulse on successful load
errorCode  output  2  0 none, 1 bad count, 2 checksum, 3 timeout; sticky

Behaviour:
- Reset is asynchronous and active-low: one clock, isResetN low clears all state immediately.
- Reset values: state IDLE, byteReady=0, writeEnable=0, writeAddress=0, writeData=0, cpuHold=0, loadDone=0, errorCode=0, checksum=0, byte and word counters 0, timeout counter 0.
- Handshake: a byte is accepted on a rising edge with byteValid && byteReady. byteReady=1 in IDLE, COUNT, DATA and CHECK; 0 in FINISH.
- Frame format: SYNC_BYTE, count N (words), N*(INSTRUCTION_WIDTH/8) data bytes MSB first, then a check byte. The check byte is the XOR of N and all data bytes.
- States:
  - IDLE: a non-sync byte is accepted and discarded. SYNC_BYTE -> COUNT; set cpuHold=1, clear errorCode, checksum, writeAddress and counters.
  - COUNT: N==0 or N > 2**PC_WIDTH -> FINISH with errorCode=1. Otherwise latch N, checksum=N, go to DATA.
  - DATA: shift each byte into the word; checksum ^= byte. When the last byte of a word is accepted, the next cycle has writeEnable=1, writeData=assembled word, and writeAddress=current word index. writeAddress increments the cycle after the strobe. After word N is written -> CHECK. A SYNC_BYTE value inside DATA is ordinary data, with no resync.
  - CHECK: byte == checksum -> FINISH, loadDone=1 for one cycle, cpuHold=0. Mismatch -> FINISH with errorCode=2, cpuHold stays 1.
  - FINISH: lasts one cycle, then IDLE.
- Write timing: write latency is 1 cycle from acceptance of a word's final byte. Back-to-back bytes are supported at 1 byte/cycle, so writes can occur every INSTRUCTION_WIDTH/8 cycles.
- Timeout: in COUNT, DATA or CHECK, the counter increments every cycle with no accepted byte and clears on acceptance. Reaching TIMEOUT_CYCLES -> FINISH with errorCode=3, cpuHold stays 1.
- On any error: words already written are not rolled back, and cpuHold remains 1 until a later successful load or reset.
- Reset mid-frame: the frame is abandoned, outputs return to reset values, and cpuHold=0.
- Width rules: the word counter is PC_WIDTH+1 bits, so N = 2**PC_WIDTH is legal. The byte counter is clog2(INSTRUCTION_WIDTH/8) bits and wraps per word.

Decomposition:
- Shared package loader_pkg: state enum (IDLE, COUNT, DATA, CHECK, FINISH), error-code constants, default SYNC_BYTE.
- One sub-module, word_assembler: byte shift register plus byte counter, emitting wordValid and word.
- The FSM, checksum and timeout logic stay in program_loader.

Test Plan:
- Load one word: A5 01 12 34 56 78 09 -> single writeEnable with addr 0, data 0x12345678; loadDone pulse; cpuHold 1 -> 0; errorCode 0.
- Load three words back-to-back with byteValid held high -> writes at addr 0,1,2 spaced 4 cycles apart; correct data; loadDone.
- Bad check: A5 01 12 34 56 78 00 -> word still written; errorCode=2; cpuHold stays 1; no loadDone.
- Count 0: A5 00 -> errorCode=1 immediately; no writes. A following valid frame clears errorCode and loads.
- Timeout: A5 02 then silence for TIMEOUT_CYCLES -> errorCode=3, state IDLE. Also: drop isResetN mid-DATA -> outputs go to reset values asynchronously, before the next clock edge.
- Garbage before sync: 00 FF A5 01 ... -> leading bytes ignored; load succeeds.
